mem_access_stage: RTL

- MEM stage of the pipeline, between the EX/MEM register and the MEM/WB register (`MEM_WB_stage`).
- Runs loads and stores against a variable-latency data memory using a req/ack handshake.
- Stalls upstream stages until the access completes.
- Drives `waddr`/`dmrdata`/`aluout`/`wen`/`memtoreg`/`jal`/`nPC` into MEM/WB, and inserts a bubble (`wen_out`=0) while stalled.

---
 rtl/mem_access_stage_pkg.sv | 21 ++
 rtl/mem_access_stage_mem_req_ctrl.sv | 147 ++++++++++++++
 rtl/mem_access_stage.sv | 85 ++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared widths, MEM-stage FSM encoding and the data-memory timeout default.
// Imported by mem_req_ctrl and mem_access_stage.
package mem_access_stage_pkg;

   localparam int ASIZE       = 5;
   localparam int DSIZE       = 32;
   localparam int ISIZE       = 32;
   localparam int TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;

   // A combined load+store is treated as a store by the callers.
   function automatic logic is_mem_op(input logic rd, input logic wr);
      return rd | wr;
   endfunction

endpackage

// File: rtl/mem_access_stage_mem_req_ctrl.sv
// mem_req_ctrl: data-memory req/ack FSM, registered dm_* bus, stall generation.
// Optional abort of a stuck access under `DM_TIMEOUT_EN (sticky dm_err).
module mem_req_ctrl
   import mem_access_stage_pkg::*;
#(
   parameter int DW             = DSIZE,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mem_op_i,
   input  logic          we_i,
   input  logic [DW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          dm_ack_i,
   input  logic [DW-1:0] dm_rdata_i,
   output mem_state_e    state_o,
   output logic          stall_o,
   output logic [DW-1:0] rdata_o,
   output logic          dm_req_o,
   output logic          dm_we_o,
   output logic [DW-1:0] dm_addr_o,
   output logic [DW-1:0] dm_wdata_o,
   output logic          dm_err_o
);

   mem_state_e    state_q, state_d;
   logic          dm_req_q, dm_req_d;
   logic          dm_we_q, dm_we_d;
   logic [DW-1:0] dm_addr_q, dm_addr_d;
   logic [DW-1:0] dm_wdata_q, dm_wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          timeout;

   always_ff @(posedge clk) begin
      // NOTE: state elements use non-blocking assignments and a synchronous reset, so every
      // register samples the values that existed before this edge.
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every always_comb assigns a default first so no path leaves a latch behind.
   always_comb begin : next_state
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (mem_op_i)             state_d = ST_WAIT;
         ST_WAIT: if (dm_ack_i || timeout)  state_d = ST_DONE;
         ST_DONE:                           state_d = ST_IDLE;
         default:                           state_d = ST_IDLE;
      endcase
   end

   always_comb begin : fsm_outputs
      stall_o = 1'b0;
      unique case (state_q)
         ST_IDLE: stall_o = mem_op_i;
         ST_WAIT: stall_o = 1'b1;
         default: stall_o = 1'b0;
      endcase
   end

   // Request bus is captured once on leaving IDLE and held untouched through WAIT.
   always_comb begin : datapath
      dm_req_d   = dm_req_q;
      dm_we_d    = dm_we_q;
      dm_addr_d  = dm_addr_q;
      dm_wdata_d = dm_wdata_q;
      rdata_d    = rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (mem_op_i) begin
               dm_req_d   = 1'b1;
               dm_we_d    = we_i;
               dm_addr_d  = addr_i;
               dm_wdata_d = wdata_i;
            end
         end
         ST_WAIT: begin
            if (dm_ack_i) begin
               dm_req_d = 1'b0;
               rdata_d  = dm_we_q ? '0 : dm_rdata_i;
            end else if (timeout) begin
               dm_req_d = 1'b0;
               rdata_d  = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dm_req_q   <= 1'b0;
         dm_we_q    <= 1'b0;
         dm_addr_q  <= '0;
         dm_wdata_q <= '0;
         rdata_q    <= '0;
      end else begin
         dm_req_q   <= dm_req_d;
         dm_we_q    <= dm_we_d;
         dm_addr_q  <= dm_addr_d;
         dm_wdata_q <= dm_wdata_d;
         rdata_q    <= rdata_d;
      end
   end

`ifdef DM_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   // An ack in the last allowed cycle still wins over the abort.
   assign timeout = (state_q == ST_WAIT) && !dm_ack_i &&
                    (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin : timeout_next
      cnt_d = cnt_q;
      err_d = err_q | timeout;
      if (state_q == ST_IDLE)                    cnt_d = '0;
      else if (state_q == ST_WAIT && !dm_ack_i)  cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign dm_err_o = err_q;
`else
   assign timeout  = 1'b0;
   assign dm_err_o = 1'b0;
`endif

   assign state_o    = state_q;
   assign rdata_o    = rdata_q;
   assign dm_req_o   = dm_req_q;
   assign dm_we_o    = dm_we_q;
   assign dm_addr_o  = dm_addr_q;
   assign dm_wdata_o = dm_wdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage; runs loads/stores on a req/ack data memory,
// stalls upstream meanwhile and feeds MEM/WB. Optional abort via `DM_TIMEOUT_EN.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int AW             = ASIZE,
   parameter int DW             = DSIZE,
   parameter int IW             = ISIZE,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] waddr_in,
   input  logic [DW-1:0] aluout_in,
   input  logic [DW-1:0] stdata_in,
   input  logic          memread_in,
   input  logic          memwrite_in,
   input  logic          wen_in,
   input  logic          memtoreg_in,
   input  logic          jal_in,
   input  logic [IW-1:0] nPC_in,
   output logic [AW-1:0] waddr_out,
   output logic [DW-1:0] dmrdata_out,
   output logic [DW-1:0] aluout_out,
   output logic          wen_out,
   output logic          memtoreg_out,
   output logic          jal_out,
   output logic [IW-1:0] nPC_out,
   output logic          stall_out,
   output logic          dm_req,
   output logic          dm_we,
   output logic [DW-1:0] dm_addr,
   output logic [DW-1:0] dm_wdata,
   input  logic          dm_ack,
   input  logic [DW-1:0] dm_rdata,
   output logic          dm_err
);

   mem_state_e    state;
   logic          stall;
   logic [DW-1:0] rdata;

   mem_req_ctrl #(
      .DW             (DW),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .mem_op_i   (is_mem_op(memread_in, memwrite_in)),
      .we_i       (memwrite_in),
      .addr_i     (aluout_in),
      .wdata_i    (stdata_in),
      .dm_ack_i   (dm_ack),
      .dm_rdata_i (dm_rdata),
      .state_o    (state),
      .stall_o    (stall),
      .rdata_o    (rdata),
      .dm_req_o   (dm_req),
      .dm_we_o    (dm_we),
      .dm_addr_o  (dm_addr),
      .dm_wdata_o (dm_wdata),
      .dm_err_o   (dm_err)
   );

   // Inputs are frozen upstream while stalled, so DONE can forward them directly.
   always_comb begin : wb_mux
      waddr_out    = waddr_in;
      aluout_out   = aluout_in;
      nPC_out      = nPC_in;
      wen_out      = wen_in;
      memtoreg_out = memtoreg_in;
      jal_out      = jal_in;
      dmrdata_out  = '0;
      if (state == ST_DONE) begin
         dmrdata_out = rdata;
      end else if (stall) begin
         wen_out      = 1'b0;
         memtoreg_out = 1'b0;
         jal_out      = 1'b0;
      end
   end

   assign stall_out = stall;

endmodule
